data_table_reader: RTL and testbench

DATA_TABLE_READER -- requirements
Module: data_table_reader

---
 rtl/data_table_reader.sv | 127 ++++++++++++
 tb/tb_data_table_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_table_reader.sv
// Burst reader for a single-port table RAM: walks base..base+length-1 (wrapping),
// keeps at most two words buffered or in flight, and streams them out with valid/ready.
module data_table_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 38
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic [ADDR_WIDTH:0] sat_len(input logic [ADDR_WIDTH:0] l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  state_t                state;
  logic [ADDR_WIDTH:0]   reads_left;
  logic                  iss_p0, iss_last_p0;
  logic                  vld_p1, last_p1;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] buf_data_p2 [2];
  logic                  buf_last_p2 [2];

  logic [1:0]            nxt_cnt;
  logic [DATA_WIDTH-1:0] nxt_data [2];
  logic                  nxt_last [2];
  logic [ADDR_WIDTH:0]   len_sat;
  logic [2:0]            occ;
  logic                  pop, issue;

  assign len_sat = sat_len(length);
  assign m_valid = (buf_cnt != 2'd0) || vld_p1;
  assign m_data  = (buf_cnt != 2'd0) ? buf_data_p2[0] : (vld_p1 ? rd_data : '0);
  assign m_last  = (buf_cnt != 2'd0) ? buf_last_p2[0] : (vld_p1 & last_p1);
  assign pop     = m_valid & m_ready;
  // Occupancy counts the read on rd_addr this cycle, the word on rd_data, and the buffer.
  assign occ     = {1'b0, buf_cnt} + {2'b00, iss_p0} + {2'b00, vld_p1};
  assign issue   = (state == RUN) && (reads_left != '0) &&
                   ((occ < 3'd2) || ((occ == 3'd2) && pop));

  always_comb begin
    nxt_cnt  = buf_cnt;
    nxt_data = buf_data_p2;
    nxt_last = buf_last_p2;
    if (pop && (buf_cnt != 2'd0)) begin
      nxt_data[0] = buf_data_p2[1];
      nxt_last[0] = buf_last_p2[1];
      nxt_cnt     = buf_cnt - 2'd1;
    end
    // The arriving RAM word is buffered unless it went straight out this cycle.
    if (vld_p1 && !(pop && (buf_cnt == 2'd0))) begin
      nxt_data[nxt_cnt[0]] = rd_data;
      nxt_last[nxt_cnt[0]] = last_p1;
      nxt_cnt              = nxt_cnt + 2'd1;
    end
  end

  // Stage p0: address issue / p1: RAM word arriving / p2: output buffer
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state       <= IDLE;
      reads_left  <= '0;
      iss_p0      <= 1'b0;
      iss_last_p0 <= 1'b0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      buf_cnt     <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_addr     <= '0;
    end else begin
      done    <= 1'b0;
      iss_p0  <= 1'b0;
      vld_p1  <= iss_p0;
      last_p1 <= iss_last_p0;
      buf_cnt <= nxt_cnt;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (len_sat == '0) begin
            done <= 1'b1;
          end else begin
            rd_addr     <= base_addr;
            iss_p0      <= 1'b1;
            iss_last_p0 <= (len_sat == ONE);
            reads_left  <= len_sat - ONE;
            busy        <= 1'b1;
            state       <= (len_sat == ONE) ? DRAIN : RUN;
          end
        end
        RUN: if (issue) begin
          rd_addr     <= rd_addr + ADDR_WIDTH'(1);
          iss_p0      <= 1'b1;
          iss_last_p0 <= (reads_left == ONE);
          reads_left  <= reads_left - ONE;
          if (reads_left == ONE) state <= DRAIN;
        end
        DRAIN: if (pop && m_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk) begin
    buf_data_p2 <= nxt_data;
    buf_last_p2 <= nxt_last;
  end

endmodule

// File: tb/tb_data_table_reader.sv
// Directed bench for data_table_reader: a registered RAM model returns word_of(addr),
// and a negedge monitor records accepted beats, done pulses and stall stability.
module tb_data_table_reader;
  localparam int AW = 9;
  localparam int DW = 38;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic          done;

  data_table_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rd_clk(clk), .rd_rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {(29'(a) ^ 29'h0ABCDE5), a};
  endfunction

  always @(posedge clk) rd_data <= word_of(rd_addr);

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         beats_q[$];
  int            done_cnt = 0;
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stall_err++;
      if (m_valid && m_ready) beats_q.push_back('{d: m_data, l: m_last});
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rmode = 0;
  int rbase = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    idx = cyc - rbase;
    if (rmode == 0) m_ready = 1'b1;
    else m_ready = (idx >= 4 && idx < 9) ? 1'b0 : ((idx % 2) == 0);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      next_cycle();
      sample();
      if (done) found = 1'b1;
    end
  endtask

  task automatic check_burst(input string tag, input int base, input int len);
    int n, derr, lerr;
    n = (len > 512) ? 512 : len;
    derr = 0;
    lerr = 0;
    check({tag, "_count"}, beats_q.size(), n);
    for (int i = 0; i < beats_q.size() && i < n; i++) begin
      if (beats_q[i].d !== word_of(AW'(base + i))) derr++;
      if (beats_q[i].l !== (i == n - 1)) lerr++;
    end
    check({tag, "_data_errs"}, derr, 0);
    check({tag, "_last_errs"}, lerr, 0);
  endtask

  task automatic start_burst(input int base, input int len);
    next_cycle();
    beats_q.delete();
    done_cnt = 0;
    start = 1'b1;
    base_addr = AW'(base);
    length = (AW+1)'(len);
    rbase = cyc;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    repeat (3) next_cycle();
    sample();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_m_data", m_data, 0);
    next_cycle();
    rst = 1'b0;

    // Basic burst with back-to-back addresses and beats
    start_burst('h010, 4);
    next_cycle(); start = 1'b0;
    sample();
    check("b1_addr0", rd_addr, 'h010);
    check("b1_busy", busy, 1);
    check("b1_valid_early", m_valid, 0);
    next_cycle(); sample();
    check("b1_addr1", rd_addr, 'h011);
    check("b1_first_valid", m_valid, 1);
    check("b1_first_data", m_data, word_of(9'h010));
    next_cycle(); sample();
    check("b1_addr2", rd_addr, 'h012);
    next_cycle(); sample();
    check("b1_addr3", rd_addr, 'h013);
    wait_done(20, found);
    check("b1_done_seen", found, 1);
    check("b1_busy_at_done", busy, 1);
    next_cycle(); sample();
    check("b1_busy_after", busy, 0);
    check("b1_done_once", done_cnt, 1);
    check_burst("b1", 'h010, 4);

    // Address wrap at the top of the table
    start_burst('h1FE, 4);
    next_cycle(); start = 1'b0;
    wait_done(20, found);
    check("wrap_done_seen", found, 1);
    check_burst("wrap", 'h1FE, 4);

    // Back-pressure: toggling ready plus a long stall
    start_burst('h020, 8);
    rmode = 1;
    next_cycle(); start = 1'b0;
    wait_done(60, found);
    rmode = 0;
    check("bp_done_seen", found, 1);
    check_burst("bp", 'h020, 8);
    check("bp_stall_stable", stall_err, 0);

    // Zero length completes immediately with no beats
    start_burst('h033, 0);
    next_cycle(); start = 1'b0;
    sample();
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", m_valid, 0);
    repeat (4) next_cycle();
    sample();
    check("len0_no_beats", beats_q.size(), 0);
    check("len0_done_once", done_cnt, 1);

    // Oversized length saturates to the full table
    start_burst('h005, 600);
    next_cycle(); start = 1'b0;
    wait_done(1200, found);
    check("sat_done_seen", found, 1);
    check_burst("sat", 'h005, 600);

    // A second start while running is ignored
    start_burst('h040, 6);
    next_cycle(); start = 1'b0;
    next_cycle(); start = 1'b1; base_addr = 9'h100; length = 10'd3;
    next_cycle(); start = 1'b0;
    wait_done(30, found);
    check("ign_done_seen", found, 1);
    repeat (5) next_cycle();
    sample();
    check_burst("ign", 'h040, 6);
    check("ign_done_once", done_cnt, 1);
    check("ign_busy_idle", busy, 0);

    // Reset in the middle of a burst, then a fresh burst right after
    start_burst('h080, 10);
    next_cycle(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      next_cycle(); sample();
      if (beats_q.size() >= 3) found = 1'b1;
    end
    check("mr_three_beats", found, 1);
    next_cycle(); rst = 1'b1;
    next_cycle(); sample();
    check("mr_valid", m_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_addr", rd_addr, 0);
    check("mr_data", m_data, 0);
    check("mr_last", m_last, 0);
    check("mr_no_done", done_cnt, 0);
    next_cycle();
    rst = 1'b0;
    beats_q.delete();
    start = 1'b1; base_addr = 9'h1FF; length = 10'd2;
    next_cycle(); start = 1'b0;
    wait_done(20, found);
    check("mr2_done_seen", found, 1);
    check("mr2_done_once", done_cnt, 1);
    check_burst("mr2", 'h1FF, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
